// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: groups the control inputs and PC/RAS outputs of next_pc_unit.
// master modport: the driver (controller or testbench) side.
// slave modport : the next_pc_unit side.
// Signals:
//   stall, jump_sel, branch_taken, branch_target, jump_index, ra  (master -> slave)
//   pc, pc_plus4, next_pc, ras_top, ras_count, ras_empty, ras_full,
//   ras_overflow, ras_underflow                                   (slave -> master)
//   ras_mismatch (slave -> master), present only when NEXT_PC_RAS_CHECK_EN is defined.
interface next_pc_unit_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IMM_W     = 26,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              stall;
    logic [1:0]        jump_sel;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic [IMM_W-1:0]  jump_index;
    logic [ADDR_W-1:0] ra;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;
    logic              ras_underflow;

`ifdef NEXT_PC_RAS_CHECK_EN
    logic              ras_mismatch;

    modport master (
        output stall, jump_sel, branch_taken, branch_target, jump_index, ra,
        input  pc, pc_plus4, next_pc, ras_top, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow, ras_mismatch
    );
    modport slave (
        input  stall, jump_sel, branch_taken, branch_target, jump_index, ra,
        output pc, pc_plus4, next_pc, ras_top, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow, ras_mismatch
    );
`else
    modport master (
        output stall, jump_sel, branch_taken, branch_target, jump_index, ra,
        input  pc, pc_plus4, next_pc, ras_top, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );
    modport slave (
        input  stall, jump_sel, branch_taken, branch_target, jump_index, ra,
        output pc, pc_plus4, next_pc, ras_top, ras_count, ras_empty, ras_full,
               ras_overflow, ras_underflow
    );
`endif
endinterface

// File: rtl/next_pc_unit.sv
// next_pc_unit: next-PC selection, PC register and circular return-address stack.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - next_pc_unit_if.slave: jump_sel (11 j, 10 jr, 01 jal, 00 seq/branch),
//           stall, branch inputs, jump_index, ra; outputs pc, pc_plus4, next_pc and
//           RAS status (top, count, empty, full, overflow/underflow pulses).
// Optional: define NEXT_PC_RAS_CHECK_EN to add the registered ras_mismatch pulse,
//           raised on a non-stalled jr whose ra differs from the RAS prediction
//           (or when there is no prediction at all).
module next_pc_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       IMM_W     = 26,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    next_pc_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] SelSeq = 2'b00;
    localparam logic [1:0] SelJal = 2'b01;
    localparam logic [1:0] SelJr  = 2'b10;
    localparam logic [1:0] SelJ   = 2'b11;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4, jaddr, next_pc, ras_top;
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              empty, full, push, pop;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Region bits come from pc+4, not pc, so a jump in the delay-slot boundary
    // lands in the correct 2^(IMM_W+2) region.
    if (ADDR_W > IMM_W + 2) begin : g_region
        assign jaddr = {pc_plus4[ADDR_W-1:IMM_W+2], bus.jump_index, 2'b00};
    end else begin : g_no_region
        assign jaddr = {bus.jump_index, 2'b00};
    end

    always_comb begin
        next_pc = pc_plus4;
        unique case (bus.jump_sel)
            SelJ, SelJal: next_pc = jaddr;
            SelJr:        next_pc = bus.ra;
            SelSeq:       next_pc = bus.branch_taken ? bus.branch_target : pc_plus4;
            default:      next_pc = pc_plus4;
        endcase
    end

    // ptr_q is the next write slot; the top entry sits one below it. When full,
    // ptr_q has wrapped onto the oldest entry, so a push overwrites it.
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top_idx = ptr_q - 1'b1;
    assign ras_top = empty ? '0 : ras_mem_q[top_idx];

    assign push = !bus.stall && (bus.jump_sel == SelJal);
    assign pop  = !bus.stall && (bus.jump_sel == SelJr) && !empty;

    always_comb begin
        pc_d  = bus.stall ? pc_q : next_pc;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
        end else if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end
        ovf_d = push && full;
        unf_d = !bus.stall && (bus.jump_sel == SelJr) && empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            if (push) begin
                ras_mem_q[ptr_q] <= pc_plus4;
            end
        end
    end

`ifdef NEXT_PC_RAS_CHECK_EN
    logic mis_q, mis_d;

    assign mis_d = !bus.stall && (bus.jump_sel == SelJr) && (empty || (ras_top != bus.ra));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign bus.ras_mismatch = mis_q;
`endif

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.next_pc       = next_pc;
    assign bus.ras_top       = ras_top;
    assign bus.ras_count     = cnt_q;
    assign bus.ras_empty     = empty;
    assign bus.ras_full      = full;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule
